// File: rtl/led_shift_pkg.sv
// Shared encodings and default compare limits for the LED shift controller.
package led_shift_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L = 2'b00,
    MODE_ROT_R = 2'b01,
    MODE_PING  = 2'b10,
    MODE_FLASH = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [31:0] LIMIT0_DEFAULT = 32'd4194303;
  localparam logic [31:0] LIMIT1_DEFAULT = 32'd8388607;
  localparam logic [31:0] LIMIT2_DEFAULT = 32'd16777215;
  localparam logic [31:0] LIMIT3_DEFAULT = 32'd33554431;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow switch buses; synchronous active-low reset clears both stages.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= i_data;
      sync <= meta;
    end
  end

  assign o_data = sync;

endmodule

// File: rtl/led_shift_ctrl.sv
// Counter-limit comparator driving a one-cycle compare-reset pulse and an LED pattern engine.
// Define LED_SHIFT_SYNC_EN to pass the switch inputs through 2-flop synchronizers.
module led_shift_ctrl
  import led_shift_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           N_LEDS     = 4,
  parameter logic [DATA_WIDTH-1:0] LIMIT0     = DATA_WIDTH'(LIMIT0_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] LIMIT1     = DATA_WIDTH'(LIMIT1_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] LIMIT2     = DATA_WIDTH'(LIMIT2_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] LIMIT3     = DATA_WIDTH'(LIMIT3_DEFAULT)
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_count_data,
  input  logic [1:0]            i_sel_limit,
  input  logic [1:0]            i_mode,
  output logic                  o_comp_reset,
  output logic [N_LEDS-1:0]     o_led
);

  localparam logic [N_LEDS-1:0] LED_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] LED_MSB = {1'b1, {(N_LEDS-1){1'b0}}};

  logic [1:0]            sel_eff;
  logic [1:0]            mode_raw;
  mode_e                 mode_eff;
  logic [DATA_WIDTH-1:0] limit;
  logic                  hit;

  logic                  comp_reset_reg;
  logic [N_LEDS-1:0]     led_reg;
  logic [N_LEDS-1:0]     led_next;
  mode_e                 mode_reg;
  mode_e                 mode_next;
  dir_e                  dir_reg;
  dir_e                  dir_next;

`ifdef LED_SHIFT_SYNC_EN
  sync_2ff #(
    .WIDTH (2)
  ) u_sync_sel (
    .clock   (clock),
    .i_reset (i_reset),
    .i_data  (i_sel_limit),
    .o_data  (sel_eff)
  );

  sync_2ff #(
    .WIDTH (2)
  ) u_sync_mode (
    .clock   (clock),
    .i_reset (i_reset),
    .i_data  (i_mode),
    .o_data  (mode_raw)
  );
`else
  assign sel_eff  = i_sel_limit;
  assign mode_raw = i_mode;
`endif

  assign mode_eff = mode_e'(mode_raw);

  always_comb begin
    limit = LIMIT0;
    unique case (sel_eff)
      2'd0: limit = LIMIT0;
      2'd1: limit = LIMIT1;
      2'd2: limit = LIMIT2;
      2'd3: limit = LIMIT3;
    endcase
  end

  // >= rather than == so that lowering the limit below the live count still fires.
  assign hit = (i_count_data >= limit) && !comp_reset_reg;

  function automatic logic [N_LEDS-1:0] init_pattern(mode_e m);
    unique case (m)
      MODE_ROT_L: init_pattern = LED_LSB;
      MODE_ROT_R: init_pattern = LED_MSB;
      MODE_PING:  init_pattern = LED_LSB;
      MODE_FLASH: init_pattern = '1;
    endcase
  endfunction

  always_comb begin
    led_next  = led_reg;
    mode_next = mode_reg;
    dir_next  = dir_reg;
    if (hit) begin
      if (mode_eff != mode_reg) begin
        mode_next = mode_eff;
        dir_next  = DIR_UP;
        led_next  = init_pattern(mode_eff);
      end else begin
        unique case (mode_reg)
          MODE_ROT_L: led_next = {led_reg[N_LEDS-2:0], led_reg[N_LEDS-1]};
          MODE_ROT_R: led_next = {led_reg[0], led_reg[N_LEDS-1:1]};
          MODE_PING: begin
            // Turn around on the tick that leaves an end, so no end LED is lit twice in a row.
            if (dir_reg == DIR_UP) begin
              if (led_reg[N_LEDS-1]) begin
                dir_next = DIR_DOWN;
                led_next = led_reg >> 1;
              end else begin
                led_next = led_reg << 1;
              end
            end else begin
              if (led_reg[0]) begin
                dir_next = DIR_UP;
                led_next = led_reg << 1;
              end else begin
                led_next = led_reg >> 1;
              end
            end
          end
          MODE_FLASH: led_next = ~led_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      comp_reset_reg <= 1'b0;
      led_reg        <= LED_LSB;
      mode_reg       <= MODE_ROT_L;
      dir_reg        <= DIR_UP;
    end else begin
      comp_reset_reg <= hit;
      led_reg        <= led_next;
      mode_reg       <= mode_next;
      dir_reg        <= dir_next;
    end
  end

  assign o_comp_reset = comp_reset_reg;
  assign o_led        = led_reg;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl: counter modelled in the bench, closed through o_comp_reset.
module tb_led_shift_ctrl;

  logic        clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_count_data;
  logic [1:0]  i_sel_limit;
  logic [1:0]  i_mode;
  logic        o_comp_reset;
  logic [3:0]  o_led;

  always #5 clock = ~clock;

  led_shift_ctrl #(
    .DATA_WIDTH (32),
    .N_LEDS     (4),
    .LIMIT0     (32'd4),
    .LIMIT1     (32'd8),
    .LIMIT2     (32'd2),
    .LIMIT3     (32'd16)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_count_data (i_count_data),
    .i_sel_limit  (i_sel_limit),
    .i_mode       (i_mode),
    .o_comp_reset (o_comp_reset),
    .o_led        (o_led)
  );

  typedef struct packed {
    logic       cr;
    logic [3:0] led;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] dut_ticks[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model state: lit position for the shifting modes, explicit pattern for flash.
  logic       m_cr;
  logic [3:0] m_led;
  logic [1:0] m_mode;
  bit         m_up;
  int         m_pos;
  bit         cnt_en;

  function automatic logic [31:0] lim_of(logic [1:0] s);
    case (s)
      2'd0:    return 32'd4;
      2'd1:    return 32'd8;
      2'd2:    return 32'd2;
      default: return 32'd16;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag);
    exp_t e;
    logic hit;
    logic old_cr;
    old_cr = m_cr;
    if (!i_reset) begin
      m_cr = 1'b0; m_mode = 2'd0; m_up = 1'b1; m_pos = 0; m_led = 4'b0001;
    end else begin
      hit  = (i_count_data >= lim_of(i_sel_limit)) && !m_cr;
      m_cr = hit;
      if (hit) begin
        if (i_mode != m_mode) begin
          m_mode = i_mode;
          m_up   = 1'b1;
          m_pos  = (i_mode == 2'd1) ? 3 : 0;
          m_led  = (i_mode == 2'd3) ? 4'hF : 4'(1 << m_pos);
        end else begin
          case (m_mode)
            2'd0: begin m_pos = (m_pos + 1) % 4; m_led = 4'(1 << m_pos); end
            2'd1: begin m_pos = (m_pos + 3) % 4; m_led = 4'(1 << m_pos); end
            2'd2: begin
              if (m_up && m_pos == 3) m_up = 1'b0;
              else if (!m_up && m_pos == 0) m_up = 1'b1;
              m_pos = m_up ? m_pos + 1 : m_pos - 1;
              m_led = 4'(1 << m_pos);
            end
            default: m_led = ~m_led;
          endcase
        end
      end
    end
    sb.push_back('{cr: m_cr, led: m_led});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({tag, ".cr"}, 32'(o_comp_reset), 32'(e.cr));
    check({tag, ".led"}, 32'(o_led), 32'(e.led));
    if (o_comp_reset) dut_ticks.push_back(o_led);
    if (cnt_en) i_count_data = old_cr ? 32'd0 : i_count_data + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ping_exp [12];
    int         last;
    bit         prev_cr;
    ping_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};

    m_cr = 1'b0; m_led = 4'b0001; m_mode = 2'd0; m_up = 1'b1; m_pos = 0;
    cnt_en = 1'b0;
    i_reset = 1'b0; i_count_data = 32'd0; i_sel_limit = 2'd0; i_mode = 2'd0;

    // Reset state.
    step("rst");
    step("rst");
    check("rst_cr", 32'(o_comp_reset), 32'd0);
    check("rst_led", 32'(o_led), 32'h1);

    // Rotate-left with the counter closed through o_comp_reset.
    i_reset = 1'b1;
    cnt_en  = 1'b1;
    dut_ticks.delete();
    last    = -1;
    prev_cr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step("rotl");
      if (o_comp_reset) begin
        check("rotl_width", 32'(prev_cr), 32'd0);
        if (last >= 0) check("rotl_gap", 32'(i - last), 32'd6);
        last = i;
      end
      prev_cr = o_comp_reset;
    end
    check("rotl_nticks", 32'(dut_ticks.size() >= 4), 32'd1);
    if (dut_ticks.size() >= 4) begin
      check("rotl_seq0", 32'(dut_ticks[0]), 32'h2);
      check("rotl_seq1", 32'(dut_ticks[1]), 32'h4);
      check("rotl_seq2", 32'(dut_ticks[2]), 32'h8);
      check("rotl_seq3", 32'(dut_ticks[3]), 32'h1);
    end

    // Ping-pong for 12 ticks; the first tick loads the initial pattern.
    i_mode = 2'd2;
    dut_ticks.delete();
    for (int i = 0; i < 120 && dut_ticks.size() < 12; i++) step("ping");
    check("ping_nticks", 32'(dut_ticks.size()), 32'd12);
    if (dut_ticks.size() == 12) begin
      for (int i = 0; i < 12; i++) check($sformatf("ping_seq%0d", i), 32'(dut_ticks[i]),
                                         32'(ping_exp[i]));
      for (int i = 1; i < 12; i++)
        check("ping_end_repeat", 32'((dut_ticks[i] == dut_ticks[i-1]) &&
                                     (dut_ticks[i] == 4'h1 || dut_ticks[i] == 4'h8)), 32'd0);
    end

    // Lowering the limit below the live count fires on the next edge.
    i_sel_limit = 2'd1;
    for (int i = 0; i < 30 && i_count_data != 32'd6; i++) step("sel1");
    check("sel_count6", i_count_data, 32'd6);
    i_sel_limit = 2'd2;
    step("sel2");
    check("sel2_fire", 32'(o_comp_reset), 32'd1);
    i_sel_limit = 2'd0;

    // Rotate-left load, then switch to flash mid-interval.
    i_mode = 2'd0;
    dut_ticks.delete();
    for (int i = 0; i < 20 && dut_ticks.size() < 1; i++) step("to_rotl");
    check("to_rotl_led", 32'(o_led), 32'h1);
    step("mid");
    step("mid");
    i_mode = 2'd3;
    dut_ticks.delete();
    for (int i = 0; i < 30 && dut_ticks.size() < 2; i++) begin
      step("flash");
      if (dut_ticks.size() == 0) check("flash_hold", 32'(o_led), 32'h1);
    end
    check("flash_nticks", 32'(dut_ticks.size()), 32'd2);
    if (dut_ticks.size() == 2) begin
      check("flash_load", 32'(dut_ticks[0]), 32'hF);
      check("flash_inv", 32'(dut_ticks[1]), 32'h0);
    end

    // Constant count above the limit: pulse every other cycle, never back to back.
    cnt_en       = 1'b0;
    i_count_data = 32'd0;
    step("idle");
    i_count_data = 32'd9;
    for (int i = 0; i < 4; i++) begin
      step("hold9");
      check("hold9_cr", 32'(o_comp_reset), (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Reset coincident with a pending hit wins.
    i_reset = 1'b0;
    step("rst_hit");
    check("rst_hit_cr", 32'(o_comp_reset), 32'd0);
    check("rst_hit_led", 32'(o_led), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
